// File: rtl/matrix_loader.sv
// matrix_loader: byte-stream to parallel NxN operand-pair loader (A then B, row-major).
// Optional double buffering via `define MATRIX_LOADER_DBUF_EN (fill bank + output bank).
module matrix_loader #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clear,
  output logic [N*N*W-1:0] a_flat,
  output logic [N*N*W-1:0] b_flat,
  output logic             out_valid,
  input  logic             out_ack,
  output logic             busy
);
  localparam int E  = N * N;
  localparam int CW = (E > 1) ? $clog2(E) : 1;
  typedef enum logic [1:0] {LOAD_A, LOAD_B, HOLD} state_t;
  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          out_valid_nx, take, last, done, swap;
  logic [E*W-1:0] a_fill, b_fill, a_nx, b_nx;
  assign in_ready = state != HOLD;
  assign busy     = state == LOAD_B || (state == LOAD_A && cnt != '0);
  assign take     = in_valid && in_ready && !clear;
  assign last     = cnt == CW'(E - 1);
  assign done     = take && state == LOAD_B && last;
`ifdef MATRIX_LOADER_DBUF_EN
  // completed fill bank moves to the output bank once the output side is free
  assign swap = !clear && ((done && (!out_valid || out_ack)) || (state == HOLD && out_ack));
`else
  assign swap = done;
`endif
  // next state, element counter and out_valid; clear overrides everything on the fill side
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    out_valid_nx = out_valid;
    if (take) cnt_nx = last ? '0 : cnt + 1'b1;
    if (take && last && state == LOAD_A) state_nx = LOAD_B;
`ifdef MATRIX_LOADER_DBUF_EN
    if (out_ack) out_valid_nx = 1'b0;
    if (done) state_nx = swap ? LOAD_A : HOLD;
    if (swap) begin
      state_nx     = LOAD_A;
      out_valid_nx = 1'b1;
    end
    if (clear) begin
      state_nx = LOAD_A;
      cnt_nx   = '0;
    end
`else
    if (done) state_nx = HOLD;
    if (swap) out_valid_nx = 1'b1;
    if (state == HOLD && out_ack) begin
      state_nx     = LOAD_A;
      out_valid_nx = 1'b0;
    end
    if (clear) begin
      state_nx     = LOAD_A;
      cnt_nx       = '0;
      out_valid_nx = 1'b0;
    end
`endif
  end
  // fill-bank image including the beat accepted this cycle
  always_comb begin
    a_nx = a_fill;
    b_nx = b_fill;
    if (take && state == LOAD_A) a_nx[int'(cnt)*W +: W] = in_data;
    if (take && state == LOAD_B) b_nx[int'(cnt)*W +: W] = in_data;
  end
  // control state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= LOAD_A;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      out_valid <= out_valid_nx;
    end
  end
  // fill-bank element storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_fill <= '0;
      b_fill <= '0;
    end else begin
      a_fill <= a_nx;
      b_fill <= b_nx;
    end
  end
`ifdef MATRIX_LOADER_DBUF_EN
  // output bank captures the completed pair on a swap and otherwise holds
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_flat <= '0;
      b_flat <= '0;
    end else if (swap) begin
      a_flat <= a_nx;
      b_flat <= b_nx;
    end
  end
`else
  assign a_flat = a_fill;
  assign b_flat = b_fill;
`endif
endmodule

// File: tb/tb_matrix_loader.sv
// tb_matrix_loader: directed checks of the matrix loader stream, hold, clear and reset behaviour.
module tb_matrix_loader;
  localparam int N = 4;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, clear = 1'b0, out_ack = 1'b0;
  logic in_ready, out_valid, busy;
  logic [W-1:0] in_data = '0;
  logic [N*N*W-1:0] a_flat, b_flat;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  matrix_loader #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .clear(clear), .a_flat(a_flat), .b_flat(b_flat), .out_valid(out_valid),
    .out_ack(out_ack), .busy(busy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mat(input int base);
    logic [127:0] m;
    for (int k = 0; k < 16; k++) m[k*8 +: 8] = 8'(base + k);
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic stream(input int base, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) tick();
      beat(8'(base + i));
    end
  endtask

  task automatic ack();
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
  endtask

  initial begin
    #2 rst = 1'b0;
    #2;
    check("rst_ov", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rdy", in_ready, 1);
    check("rst_a", a_flat, 0);
    @(posedge clk);
    #1 rst = 1'b1;

    stream(1, 5, 0);
    check("busy_mid", busy, 1);
    stream(6, 26, 0);
    check("ov_early", out_valid, 0);
    beat(8'd32);
    check("ov_b2b", out_valid, 1);
    check("a_b2b", a_flat, mat(1));
    check("b_b2b", b_flat, mat(17));
    check("a00", a_flat[7:0], 8'd1);
    check("a03", a_flat[31:24], 8'd4);
    check("a33", a_flat[127:120], 8'd16);
    check("b00", b_flat[7:0], 8'd17);
    check("b33", b_flat[127:120], 8'd32);
    check("busy_hold", busy, 0);
`ifdef MATRIX_LOADER_DBUF_EN
    check("rdy_swapped", in_ready, 1);
    stream(33, 32, 0);
    check("dbuf_rdy_hold", in_ready, 0);
    check("dbuf_ov_held", out_valid, 1);
    check("dbuf_a_held", a_flat, mat(1));
    ack();
    check("dbuf_ov_cont", out_valid, 1);
    check("dbuf_a2", a_flat, mat(33));
    check("dbuf_b2", b_flat, mat(49));
    check("dbuf_rdy_back", in_ready, 1);
    ack();
    check("dbuf_ov_drop", out_valid, 0);
`else
    check("rdy_hold", in_ready, 0);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_rdy", in_ready, 0);
    end
    in_valid = 1'b0;
    check("hold_a", a_flat, mat(1));
    check("hold_b", b_flat, mat(17));
    check("hold_ov", out_valid, 1);
    ack();
    check("ack_ov", out_valid, 0);
    check("ack_rdy", in_ready, 1);
    ack();
    check("stray_ack_ov", out_valid, 0);
    check("stray_ack_busy", busy, 0);
`endif

    stream(8'h50, 5, 0);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    clear    = 1'b1;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clr_busy", busy, 0);
    check("clr_rdy", in_ready, 1);
    check("clr_ov", out_valid, 0);
    stream(101, 32, 0);
    check("clr_reload_ov", out_valid, 1);
    check("clr_reload_a", a_flat, mat(101));
    check("clr_reload_b", b_flat, mat(117));
    ack();
    check("clr_ack_ov", out_valid, 0);

    stream(1, 31, 1);
    check("gap_ov_early", out_valid, 0);
    tick();
    beat(8'd32);
    check("gap_ov", out_valid, 1);
    check("gap_a", a_flat, mat(1));
    check("gap_b", b_flat, mat(17));

    rst = 1'b0;
    #1;
    check("arst_ov", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_a", a_flat, 0);
    check("arst_b", b_flat, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
    check("arst_rdy", in_ready, 1);
    check("arst_busy2", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/matrix_loader.md
Name: matrix_loader

Overview:
- Upstream feeder for the 4x4 DNS matrix multiplier.
- Accepts operand elements one byte per beat over a valid/ready stream and assembles matrix A, then matrix B, in row-major order.
- Presents both matrices as flat parallel buses with a held valid until the multiplier acknowledges consumption.
- Decouples a narrow host/DMA byte stream from the wide parallel operand interface.

Parameters:
- N, 4, matrix dimension (N x N elements per matrix)
- W, 8, element width in bits

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low
- in_data  input  W  element byte
- in_valid  input  1  in_data valid this cycle
- in_ready  output  1  loader can accept a beat this cycle
- clear  input  1  synchronous abort: discard any partial load
- a_flat  output  N*N*W  matrix A; element (r,c) at bits [(r*N+c)*W +: W]
- b_flat  output  N*N*W  matrix B; same packing
- out_valid  output  1  a_flat/b_flat hold a complete operand pair
- out_ack  input  1  multiplier has taken the pair (single-cycle pulse)
- busy  output  1  partial load in progress (beat count nonzero and pair not complete)

Behaviour:
- Beat accepted iff in_valid && in_ready on a rising edge; in_valid gaps are legal and change nothing.
- States: LOAD_A, LOAD_B, HOLD. Element counter cnt: 0..N*N-1.
- LOAD_A:
  - Accepted beat writes A element cnt; cnt increments.
  - On beat N*N-1, cnt wraps to 0 and state goes to LOAD_B.
- LOAD_B:
  - Accepted beat writes B element cnt; cnt increments.
  - On beat N*N-1, cnt wraps to 0, state goes to HOLD, and out_valid is registered high.
  - Latency: out_valid is 1 in the first cycle after the edge that accepted the 2*N*N-th beat.
- HOLD:
  - in_ready = 0.
  - a_flat/b_flat must not change while out_valid = 1.
  - out_ack = 1 clears out_valid at the next edge and returns to LOAD_A.
  - in_ready rises in the same cycle out_valid falls.
- in_ready is combinational: 1 in LOAD_A/LOAD_B, 0 in HOLD.
- out_ack while out_valid = 0 is ignored.
- clear (synchronous) takes priority over every other event in the same cycle:
  - Next state LOAD_A, cnt = 0, out_valid = 0.
  - A beat presented in the clear cycle is dropped.
  - Data registers keep their contents.
- Reset (asynchronous, rst low), effective immediately, including mid-load or mid-HOLD:
  - State LOAD_A, cnt = 0.
  - out_valid = 0, busy = 0, a_flat = 0, b_flat = 0.
  - in_ready = 1 once the loader is in LOAD_A.
- busy = 1 when state is LOAD_B, or state is LOAD_A with cnt != 0.
- No arithmetic on data. The counter is ceil(log2(N*N)) bits wide and wraps exactly at N*N-1.

Optional Feature:
- Macro: MATRIX_LOADER_DBUF_EN.
- Defined: two storage banks (fill bank, output bank).
  - Loading of the next pair continues while out_valid = 1.
  - When the fill bank completes with the output bank free (out_valid = 0, or out_ack in the same cycle), the banks swap at that edge and out_valid = 1 next cycle.
  - When the fill bank completes while the output bank is held, the loader enters HOLD (in_ready = 0).
  - The next out_ack then presents the pending pair at the following edge; out_valid stays 1 without a low cycle, and in_ready returns to 1.
  - clear discards only the fill bank; a held output pair is unaffected.
- Not defined: single bank; behaviour exactly as above (no loading during HOLD).

Test Plan:
- Back-to-back beats with values 1..32 -> out_valid = 1 one cycle after beat 32; A(0,0)=1, A(0,3)=4, A(3,3)=16, B(0,0)=17, B(3,3)=32; busy = 0 in HOLD.
- Same stream with in_valid low every other cycle -> identical a_flat/b_flat; out_valid one cycle after the last accepted beat.
- In HOLD, drive in_valid = 1 with data 0xFF for 5 cycles -> in_ready = 0 and no element changes; out_ack pulse -> out_valid = 0 and in_ready = 1 next cycle.
- After 5 A beats assert clear with a valid beat 0xAA -> 0xAA dropped, cnt = 0, busy = 0; a fresh 32 beats load correctly.
- Pull rst low mid-HOLD for 1 cycle -> out_valid, busy, a_flat and b_flat go to 0 immediately; LOAD_A with in_ready = 1 after release.
- (DBUF_EN) Load pair 1, then stream pair 2 without ack -> pair 2 fills with in_ready = 0 after beat 64; ack -> pair 2 appears next cycle with out_valid continuously 1.
